// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int unsigned N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set bit of mask scanning upward from ptr, modulo 4.
module rr_pick_4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  logic [1:0]       ptr,
  output logic [1:0]       idx,
  output logic             found
);

  // Scan from the farthest offset down so the nearest set bit overwrites earlier hits.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (mask[ptr + 2'(i)]) begin
        idx   = ptr + 2'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux; one-hot grant plus registered select, with
// bounded hold time when other sources are waiting.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       sel,
  output logic             busy
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [1:0]       sel_q;
  logic             busy_q;
  logic [1:0]       ptr_q;
  logic [HW-1:0]    hold_q;

  logic [1:0]       holder;
  logic [N_REQ-1:0] cand;
  logic             keep;
  logic [1:0]       pick_idx;
  logic             pick_found;

  // gnt_q is zero in IDLE, so req & ~gnt_q covers the idle pick, forced rotation and handoff.
  always_comb begin
    holder = onehot_to_idx(gnt_q);
    cand   = req & ~gnt_q;
    keep   = (state_q == GRANT) && req[holder] &&
             ((cand == '0) || (hold_q < HOLD_LAST));
  end

  rr_pick_4 u_pick (
    .mask  (cand),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else if (keep) begin
      if (hold_q != HOLD_SAT) hold_q <= hold_q + 1'b1;
    end else if (pick_found) begin
      state_q <= GRANT;
      gnt_q   <= 4'b0001 << pick_idx;
      sel_q   <= pick_idx;
      busy_q  <= 1'b1;
      ptr_q   <= pick_idx + 2'd1;
      hold_q  <= '0;
    end else begin
      // Nobody requesting: drop to idle, sel keeps the last grant index.
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: MAX_HOLD=8 and MAX_HOLD=1 arbiters against a queue-free behavioural
// model, plus the 8-hold arbiter driving a 4:1 mux select.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req8 = '0, req1 = '0;
  logic [3:0] gnt8, gnt1;
  logic [1:0] sel8, sel1;
  logic       busy8, busy1;
  logic [3:0] mux_data = 4'b0001;
  logic       mux_y;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .gnt(gnt8), .sel(sel8), .busy(busy8)
  );
  mux4_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .sel(sel1), .busy(busy1)
  );

  assign mux_y = mux_data[sel8];

  // Behavioural model: holder index (-1 idle), cycles held so far, scan start, last select.
  int         m_holder[2];
  int         m_run[2];
  int         m_ptr[2];
  logic [1:0] m_sel[2];
  int         mh[2] = '{8, 1};
  int         waitc[2][4];

  function automatic int rr_pick(logic [3:0] c, int start);
    for (int k = 0; k < 4; k++) if (c[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_holder[d] = -1; m_run[d] = 0; m_ptr[d] = 0; m_sel[d] = 2'd0;
      for (int i = 0; i < 4; i++) waitc[d][i] = 0;
    end
  endfunction

  function automatic void model_grant(int d, int w);
    m_holder[d] = w; m_run[d] = 1; m_ptr[d] = (w + 1) % 4; m_sel[d] = 2'(w);
  endfunction

  function automatic void model_step(int d, logic [3:0] r);
    logic [3:0] others;
    if (m_holder[d] < 0) begin
      if (r != 0) model_grant(d, rr_pick(r, m_ptr[d]));
    end else begin
      others = r & ~(4'b0001 << m_holder[d]);
      if (r[m_holder[d]] && (others == 0 || m_run[d] < mh[d])) m_run[d]++;
      else if (others != 0) model_grant(d, rr_pick(others, m_ptr[d]));
      else m_holder[d] = -1;
    end
    for (int i = 0; i < 4; i++)
      waitc[d][i] = (r[i] && m_holder[d] != i) ? waitc[d][i] + 1 : 0;
  endfunction

  function automatic logic [3:0] exp_gnt(int d);
    return (m_holder[d] < 0) ? 4'b0000 : (4'b0001 << m_holder[d]);
  endfunction

  function automatic logic [3:0] act_gnt(int d);
    return d == 0 ? gnt8 : gnt1;
  endfunction
  function automatic logic [1:0] act_sel(int d);
    return d == 0 ? sel8 : sel1;
  endfunction
  function automatic logic act_busy(int d);
    return d == 0 ? busy8 : busy1;
  endfunction

  task automatic tick(input logic [3:0] r8, input logic [3:0] r1);
    req8 = r8;
    req1 = r1;
    @(posedge clk);
    model_step(0, r8);
    model_step(1, r1);
    #1;
  endtask

  task automatic do_reset();
    req8 = '0; req1 = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req8 = 4'b1111; req1 = 4'b1111; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    vectors++;
    if (gnt8 !== 4'b0000 || sel8 !== 2'b00 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: gnt=%b sel=%b busy=%b, want 0000/00/0", gnt8, sel8, busy8);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(4'b1111, 4'b1111);
    vectors++;
    if (gnt8 !== 4'b0001 || sel8 !== 2'b00 || busy8 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_grant: gnt=%b sel=%b busy=%b, want 0001/00/1",
               gnt8, sel8, busy8);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] want8, want1;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      tick(4'b1111, 4'b1111);
      want8 = 4'b0001 << ((c / 8) % 4);
      want1 = 4'b0001 << (c % 4);
      vectors++;
      if (gnt8 !== want8 || gnt8 !== exp_gnt(0)) begin
        miscompares++;
        $display("FAIL fairness8 c=%0d: gnt=%b, want %b", c, gnt8, want8);
      end
      vectors++;
      if (gnt1 !== want1) begin
        miscompares++;
        $display("FAIL fairness1 c=%0d: gnt=%b, want %b", c, gnt1, want1);
      end
    end
  endtask

  task automatic test_handoff();
    do_reset();
    tick(4'b0100, 4'b0000);
    vectors++;
    if (gnt8 !== 4'b0100 || sel8 !== 2'b10) begin
      miscompares++;
      $display("FAIL handoff_setup: gnt=%b sel=%b, want 0100/10", gnt8, sel8);
    end
    tick(4'b1001, 4'b0000);
    vectors++;
    if (gnt8 !== 4'b1000 || sel8 !== 2'b11 || busy8 !== 1'b1) begin
      miscompares++;
      $display("FAIL handoff: gnt=%b sel=%b busy=%b, want 1000/11/1", gnt8, sel8, busy8);
    end
  endtask

  task automatic test_solo_hold();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick(4'b0010, 4'b0010);
      if (gnt8 !== 4'b0010 || gnt1 !== 4'b0010) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL solo_hold: %0d cycles off-grant, want 0", bad);
    end
    tick(4'b0000, 4'b0000);
    vectors++;
    if (gnt8 !== 4'b0000 || sel8 !== 2'b01 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL solo_release: gnt=%b sel=%b busy=%b, want 0000/01/0", gnt8, sel8, busy8);
    end
  endtask

  task automatic test_maxhold1();
    logic [3:0] want;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(4'b0000, 4'b0101);
      want = (c % 2 == 0) ? 4'b0001 : 4'b0100;
      vectors++;
      if (gnt1 !== want) begin
        miscompares++;
        $display("FAIL maxhold1 c=%0d: gnt=%b, want %b", c, gnt1, want);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mux_data = 4'b0001;
    tick(4'b1000, 4'b0000);
    vectors++;
    if (gnt8 !== 4'b1000 || mux_y !== 1'b0) begin
      miscompares++;
      $display("FAIL async_setup: gnt=%b y=%b, want 1000/0", gnt8, mux_y);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (gnt8 !== 4'b0000 || sel8 !== 2'b00 || busy8 !== 1'b0 || mux_y !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: gnt=%b sel=%b busy=%b y=%b, want 0000/00/0/1",
               gnt8, sel8, busy8, mux_y);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] r8, r1;
    do_reset();
    r8 = '0; r1 = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) r8[i] = ~r8[i];
        if ($urandom_range(0, 3) == 0) r1[i] = ~r1[i];
      end
      mux_data = 4'($urandom);
      tick(r8, r1);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act_gnt(d) !== exp_gnt(d) || act_sel(d) !== m_sel[d] ||
            act_busy(d) !== (m_holder[d] >= 0)) begin
          miscompares++;
          $display("FAIL random d=%0d c=%0d: gnt=%b sel=%b busy=%b, want %b/%b/%b", d, c,
                   act_gnt(d), act_sel(d), act_busy(d), exp_gnt(d), m_sel[d],
                   m_holder[d] >= 0);
        end
        for (int i = 0; i < 4; i++) begin
          vectors++;
          if (waitc[d][i] > 3 * mh[d]) begin
            miscompares++;
            $display("FAIL starvation d=%0d src=%0d: waited %0d, limit %0d", d, i,
                     waitc[d][i], 3 * mh[d]);
          end
        end
      end
      vectors++;
      if (mux_y !== mux_data[m_sel[0]]) begin
        miscompares++;
        $display("FAIL mux_out c=%0d: y=%b, want %b", c, mux_y, mux_data[m_sel[0]]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fairness();
    test_handoff();
    test_solo_hold();
    test_maxhold1();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
